// File: rtl/definitions_pkg.sv
// Shared memory-access types and helpers for the memory request path.
// Used by the alignment front end and the array port interface.
package definitions;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_access_size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } mem_align_state_t;

    function automatic logic [2:0] mem_size_bytes(
        input mem_access_size_t size
    );
        case (size)
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic mem_is_aligned(
        input logic [1:0]       addr_lo,
        input mem_access_size_t size
    );
        case (size)
            BYTE:    return 1'b1;
            HALF:    return ~addr_lo[0];
            default: return addr_lo == 2'b00;
        endcase
    endfunction

    function automatic logic [31:0] mem_load_extend(
        input logic [31:0]      data,
        input mem_access_size_t size,
        input logic             sgn
    );
        case (size)
            BYTE:    return {{24{sgn & data[7]}}, data[7:0]};
            HALF:    return {{16{sgn & data[15]}}, data[15:0]};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_array_if.sv
// Port toward the memory array; read data is combinational on the
// same cycle as the read address.
interface mem_array_if;
    import definitions::*;

    logic [31:0]      rd_addr;
    mem_access_size_t rd_size;
    logic [31:0]      rd_data;
    logic             wr_enable;
    logic [31:0]      wr_addr;
    mem_access_size_t wr_size;
    logic [31:0]      wr_data;

    modport slave (
        output rd_addr, rd_size,
        output wr_enable, wr_addr, wr_size, wr_data,
        input  rd_data
    );

    modport master (
        input  rd_addr, rd_size,
        input  wr_enable, wr_addr, wr_size, wr_data,
        output rd_data
    );

endinterface

// File: rtl/mem_align_unit.sv
// Memory request front end: aligned accesses pass through in one cycle,
// misaligned ones are split into byte accesses and reassembled.
module mem_align_unit
    import definitions::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [31:0]      req_addr_i,
    input  mem_access_size_t req_size_i,
    input  logic             req_signed_i,
    input  logic [31:0]      req_data_i,
    output logic             resp_valid_o,
    output logic [31:0]      resp_data_o,
    mem_array_if.slave       memif
);

    mem_align_state_t state_q, state_d;

    logic [1:0]       idx_q;
    logic [31:0]      addr_q;
    mem_access_size_t size_q;
    logic             write_q;
    logic             signed_q;
    logic [31:0]      data_q;
    logic [31:0]      acc_q, acc_d;

    logic             aligned;
    logic             last;
    logic [7:0]       rd_byte;

    logic             acc_en;
    logic             acc_write;
    logic [31:0]      acc_addr;
    mem_access_size_t acc_size;
    logic [31:0]      acc_data;

    assign req_ready_o = (state_q == IDLE);
    assign aligned     = mem_is_aligned(req_addr_i[1:0], req_size_i);
    assign last        = ({1'b0, idx_q} == mem_size_bytes(size_q) - 3'd1);
    assign rd_byte     = memif.rd_data[7:0];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        acc_en    = 1'b0;
        acc_write = 1'b0;
        acc_addr  = 32'h0;
        acc_size  = WORD;
        acc_data  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    acc_en    = 1'b1;
                    acc_write = req_write_i;
                    acc_addr  = req_addr_i;
                    if (aligned) begin
                        acc_size = req_size_i;
                        acc_data = req_data_i;
                    end else begin
                        acc_size = BYTE;
                        acc_data = {24'h0, req_data_i[7:0]};
                        state_d  = SPLIT;
                        if (!req_write_i)
                            acc_d = {24'h0, rd_byte};
                    end
                end
            end
            SPLIT: begin
                acc_en    = 1'b1;
                acc_write = write_q;
                acc_addr  = addr_q + {30'h0, idx_q};
                acc_size  = BYTE;
                acc_data  = {24'h0, data_q[{idx_q, 3'b000} +: 8]};
                if (!write_q)
                    acc_d[{idx_q, 3'b000} +: 8] = rd_byte;
                if (last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Only one side of the port is active; the other sits at idle values.
    always_comb begin
        memif.rd_addr   = 32'h0;
        memif.rd_size   = WORD;
        memif.wr_enable = 1'b0;
        memif.wr_addr   = 32'h0;
        memif.wr_size   = WORD;
        memif.wr_data   = 32'h0;
        if (acc_en && acc_write) begin
            memif.wr_enable = 1'b1;
            memif.wr_addr   = acc_addr;
            memif.wr_size   = acc_size;
            memif.wr_data   = acc_data;
        end else if (acc_en) begin
            memif.rd_addr = acc_addr;
            memif.rd_size = acc_size;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            idx_q        <= 2'd0;
            addr_q       <= 32'h0;
            size_q       <= WORD;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            data_q       <= 32'h0;
            acc_q        <= 32'h0;
            resp_valid_o <= 1'b0;
            resp_data_o  <= 32'h0;
        end else begin
            resp_valid_o <= 1'b0;
            acc_q        <= acc_d;
            unique case (state_q)
                IDLE: begin
                    if (req_valid_i && aligned) begin
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= req_write_i ? 32'h0 :
                            mem_load_extend(memif.rd_data,
                                            req_size_i,
                                            req_signed_i);
                    end else if (req_valid_i) begin
                        addr_q   <= req_addr_i;
                        size_q   <= req_size_i;
                        write_q  <= req_write_i;
                        signed_q <= req_signed_i;
                        data_q   <= req_data_i;
                        idx_q    <= 2'd1;
                    end
                end
                SPLIT: begin
                    if (last) begin
                        idx_q        <= 2'd0;
                        resp_valid_o <= 1'b1;
                        resp_data_o  <= write_q ? 32'h0 :
                            mem_load_extend(acc_d, size_q, signed_q);
                    end else begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                default: idx_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: byte-array memory, directed scenarios and
// random requests checked against a byte-level reference memory.
module tb_mem_align_unit;
    import definitions::*;

    logic             clk_i = 1'b0;
    logic             reset_i = 1'b1;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_write_i = 1'b0;
    logic [31:0]      req_addr_i = 32'h0;
    mem_access_size_t req_size_i = BYTE;
    logic             req_signed_i = 1'b0;
    logic [31:0]      req_data_i = 32'h0;
    logic             resp_valid_o;
    logic [31:0]      resp_data_o;

    mem_array_if memif();

    mem_align_unit dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_write_i  (req_write_i),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_data_i   (req_data_i),
        .resp_valid_o (resp_valid_o),
        .resp_data_o  (resp_data_o),
        .memif        (memif)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [4096];
    logic [7:0]  ref_mem [4096];
    logic        bd_en = 1'b0;
    logic [11:0] bd_addr = 12'h0;
    logic [7:0]  bd_data = 8'h0;

    function automatic int nbytes(input mem_access_size_t s);
        return (s == BYTE) ? 1 : (s == HALF) ? 2 : 4;
    endfunction

    always_comb begin
        memif.rd_data = 32'h0;
        for (int k = 0; k < 4; k++)
            if (k < nbytes(memif.rd_size))
                memif.rd_data[8*k +: 8] =
                    mem[12'(memif.rd_addr + 32'(k))];
    end

    always @(posedge clk_i) begin
        if (bd_en)
            mem[bd_addr] <= bd_data;
        else if (memif.wr_enable)
            for (int k = 0; k < 4; k++)
                if (k < nbytes(memif.wr_size))
                    mem[12'(memif.wr_addr + 32'(k))] <=
                        memif.wr_data[8*k +: 8];
    end

    task automatic set_byte(input logic [31:0] a, input logic [7:0] v);
        @(negedge clk_i);
        bd_en   = 1'b1;
        bd_addr = a[11:0];
        bd_data = v;
        ref_mem[a[11:0]] = v;
        @(posedge clk_i);
        #1 bd_en = 1'b0;
    endtask

    // One request driven to completion with per-cycle bus checks.
    task automatic do_req(input string nm, input bit wr,
                          input logic [31:0] a,
                          input mem_access_size_t sz,
                          input bit sg, input logic [31:0] d);
        int n;
        bit al;
        logic [31:0] expv, ea, ed, msk;
        mem_access_size_t es;
        n  = nbytes(sz);
        al = (a % 32'(n)) == 32'h0;
        expv = 32'h0;
        if (wr) begin
            for (int k = 0; k < n; k++)
                ref_mem[12'(a + 32'(k))] = d[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++)
                expv = expv | (32'(ref_mem[12'(a + 32'(k))]) << (8*k));
            if (sg && n < 4 && expv[8*n-1])
                expv = expv | (32'hFFFF_FFFF << (8*n));
        end
        @(negedge clk_i);
        req_valid_i  = 1'b1;
        req_write_i  = wr;
        req_addr_i   = a;
        req_size_i   = sz;
        req_signed_i = sg;
        req_data_i   = d;
        for (int k = 0; k < (al ? 1 : n); k++) begin
            if (k > 0) begin
                @(negedge clk_i);
                req_valid_i = 1'($urandom);
                req_write_i = 1'($urandom);
                req_addr_i  = $urandom;
                req_size_i  = HALF;
                req_data_i  = $urandom;
            end
            #1;
            ea  = al ? a : a + 32'(k);
            es  = al ? sz : BYTE;
            ed  = al ? d : (d >> (8*k));
            msk = (al && n == 4) ? 32'hFFFF_FFFF :
                  al ? ((32'h1 << (8*n)) - 32'h1) : 32'hFF;
            checks++;
            if (req_ready_o !== (k == 0)) begin
                errors++;
                $display("FAIL %s ready k=%0d: got %b exp %b",
                         nm, k, req_ready_o, k == 0);
            end
            checks++;
            if (resp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s early resp k=%0d: got %b exp 0",
                         nm, k, resp_valid_o);
            end
            if (wr) begin
                checks++;
                if (memif.wr_enable !== 1'b1 || memif.wr_addr !== ea ||
                    memif.wr_size !== es ||
                    (memif.wr_data & msk) !== (ed & msk) ||
                    memif.rd_addr !== 32'h0 || memif.rd_size !== WORD) begin
                    errors++;
                    $display("FAIL %s wr k=%0d: got en=%b a=%h s=%0d d=%h exp a=%h s=%0d d=%h",
                             nm, k, memif.wr_enable, memif.wr_addr,
                             memif.wr_size, memif.wr_data, ea, es, ed & msk);
                end
            end else begin
                checks++;
                if (memif.wr_enable !== 1'b0 || memif.rd_addr !== ea ||
                    memif.rd_size !== es) begin
                    errors++;
                    $display("FAIL %s rd k=%0d: got en=%b a=%h s=%0d exp a=%h s=%0d",
                             nm, k, memif.wr_enable, memif.rd_addr,
                             memif.rd_size, ea, es);
                end
            end
        end
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        checks++;
        if (resp_valid_o !== 1'b1 || resp_data_o !== expv) begin
            errors++;
            $display("FAIL %s resp: got v=%b d=%h exp v=1 d=%h",
                     nm, resp_valid_o, resp_data_o, expv);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4096; i++) begin
            @(negedge clk_i);
            bd_en   = 1'b1;
            bd_addr = 12'(i);
            bd_data = 8'($urandom);
            ref_mem[i] = bd_data;
        end
        @(negedge clk_i);
        bd_en = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 ||
            resp_data_o !== 32'h0) begin
            errors++;
            $display("FAIL reset outs: got rdy=%b v=%b d=%h exp 1 0 0",
                     req_ready_o, resp_valid_o, resp_data_o);
        end
        checks++;
        if (memif.wr_enable !== 1'b0 || memif.rd_addr !== 32'h0 ||
            memif.rd_size !== WORD || memif.wr_addr !== 32'h0 ||
            memif.wr_size !== WORD || memif.wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset memif: got en=%b ra=%h rs=%0d wa=%h ws=%0d wd=%h",
                     memif.wr_enable, memif.rd_addr, memif.rd_size,
                     memif.wr_addr, memif.wr_size, memif.wr_data);
        end
        reset_i = 1'b0;
        @(negedge clk_i);
        #1;
        checks++;
        if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL post-reset: got rdy=%b v=%b exp 1 0",
                     req_ready_o, resp_valid_o);
        end
    endtask

    task automatic test_aligned_word();
        set_byte(32'h100, 8'hEF);
        set_byte(32'h101, 8'hBE);
        set_byte(32'h102, 8'hAD);
        set_byte(32'h103, 8'hDE);
        do_req("aligned_word", 1'b0, 32'h100, WORD, 1'b0, 32'h0);
    endtask

    task automatic test_misaligned_store();
        logic [7:0] expb [4];
        expb = '{8'h44, 8'h33, 8'h22, 8'h11};
        do_req("mis_store", 1'b1, 32'h201, WORD, 1'b0, 32'h11223344);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[12'h201 + 12'(k)] !== expb[k]) begin
                errors++;
                $display("FAIL mis_store byte%0d: got %h exp %h",
                         k, mem[12'h201 + 12'(k)], expb[k]);
            end
        end
    endtask

    task automatic test_misaligned_half();
        set_byte(32'h301, 8'h80);
        set_byte(32'h302, 8'hFF);
        do_req("half_signed", 1'b0, 32'h301, HALF, 1'b1, 32'h0);
        do_req("half_unsigned", 1'b0, 32'h301, HALF, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] expv [3];
        bit sg [3];
        for (int i = 0; i < 3; i++) begin
            set_byte(32'h500 + 32'(i), 8'($urandom));
            sg[i] = 1'($urandom);
            expv[i] = 32'(ref_mem[12'h500 + 12'(i)]);
            if (sg[i] && expv[i] >= 32'h80)
                expv[i] = expv[i] + 32'hFFFF_FF00;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            req_valid_i = (i < 3);
            req_write_i = 1'b0;
            req_size_i  = BYTE;
            req_addr_i  = 32'h500 + 32'(i);
            req_signed_i = (i < 3) ? sg[i] : 1'b0;
            #1;
            if (i < 3) begin
                checks++;
                if (req_ready_o !== 1'b1 ||
                    memif.rd_addr !== 32'h500 + 32'(i) ||
                    memif.rd_size !== BYTE) begin
                    errors++;
                    $display("FAIL b2b issue%0d: got rdy=%b a=%h s=%0d",
                             i, req_ready_o, memif.rd_addr, memif.rd_size);
                end
            end
            if (i > 0) begin
                checks++;
                if (resp_valid_o !== 1'b1 || resp_data_o !== expv[i-1]) begin
                    errors++;
                    $display("FAIL b2b resp%0d: got v=%b d=%h exp v=1 d=%h",
                             i - 1, resp_valid_o, resp_data_o, expv[i-1]);
                end
            end
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b tail: got v=%b exp 0", resp_valid_o);
        end
    endtask

    task automatic test_wrap();
        set_byte(32'hFFFF_FFFE, 8'h11);
        set_byte(32'hFFFF_FFFF, 8'h22);
        set_byte(32'h0, 8'h33);
        set_byte(32'h1, 8'h44);
        do_req("wrap_word", 1'b0, 32'hFFFF_FFFE, WORD, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_split();
        for (int k = 1; k < 5; k++)
            set_byte(32'h400 + 32'(k), 8'h00);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 32'h401;
        req_size_i  = WORD;
        req_data_i  = 32'h55667788;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        #1;
        checks++;
        if (memif.wr_enable !== 1'b1 || memif.wr_addr !== 32'h402) begin
            errors++;
            $display("FAIL rst_split byte1: got en=%b a=%h exp 1 402",
                     memif.wr_enable, memif.wr_addr);
        end
        @(posedge clk_i);
        #1 reset_i = 1'b1;
        #1;
        checks++;
        if (memif.wr_enable !== 1'b0 || req_ready_o !== 1'b1 ||
            resp_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_split in reset: got en=%b rdy=%b v=%b",
                     memif.wr_enable, req_ready_o, resp_valid_o);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            #1;
            checks++;
            if (resp_valid_o !== 1'b0 || memif.wr_enable !== 1'b0 ||
                req_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL rst_split after c=%0d: got v=%b en=%b rdy=%b",
                         c, resp_valid_o, memif.wr_enable, req_ready_o);
            end
        end
        ref_mem[12'h401] = 8'h88;
        ref_mem[12'h402] = 8'h77;
        for (int k = 1; k < 5; k++) begin
            checks++;
            if (mem[12'h400 + 12'(k)] !== ref_mem[12'h400 + 12'(k)]) begin
                errors++;
                $display("FAIL rst_split mem%0d: got %h exp %h", k,
                         mem[12'h400 + 12'(k)], ref_mem[12'h400 + 12'(k)]);
            end
        end
    endtask

    task automatic test_random();
        mem_access_size_t sz;
        for (int i = 0; i < 40; i++) begin
            sz = mem_access_size_t'($urandom_range(0, 2));
            do_req("random", 1'($urandom),
                   32'($urandom_range(32'h800, 32'hFFF)),
                   sz, 1'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0)
                @(negedge clk_i);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_misaligned_store();
        test_misaligned_half();
        test_back_to_back();
        test_wrap();
        test_reset_mid_split();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_align_unit.md
# mem_align_unit

Request-side front end for the memory array port: accepts one load/store request at a time from the core's memory stage and drives `mem_array_if` toward the memory model. Aligned accesses pass through in a single cycle. Misaligned halfword/word accesses are split by an FSM into sequential byte accesses, and load bytes are reassembled with sign/zero extension. The block sits directly upstream of the memory array and is its only master.

## Interface
Parameters: none; addresses and data are fixed at 32 bits.

Ports:
- `clk_i` in 1: clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `req_valid_i && req_ready_o`.
- `req_write_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address.
- `req_size_i` in `mem_access_size_t`: BYTE / HALF / WORD.
- `req_signed_i` in 1: sign-extend BYTE/HALF loads.
- `req_data_i` in 32: store data, little-endian, low bytes used.
- `resp_valid_o` out 1: one-cycle pulse, access complete.
- `resp_data_o` out 32: load result, extended; 0 for stores.
- `memif` `mem_array_if.slave`: drives `rd_addr`, `rd_size`, `wr_enable`, `wr_addr`, `wr_size`, `wr_data`; samples `rd_data`, which is combinational on the same cycle.

## Operation
- Access length N = 1 if aligned (BYTE; HALF with addr[0]=0; WORD with addr[1:0]=0). Otherwise N = 2 (HALF) or 4 (WORD).
- FSM states: IDLE and SPLIT. A byte index `idx` (2 bits) counts bytes.
- IDLE:
  - `req_ready_o`=1.
  - On accept, issue the first access combinationally in the same cycle: the full-size access if aligned, else a BYTE access at `req_addr_i` with data byte 0.
  - If misaligned: latch addr/size/write/signed/data, set `idx`=1, go to SPLIT.
- SPLIT:
  - `req_ready_o`=0.
  - Issue a BYTE access at `addr + idx` (mod 2^32, wraps past 0xFFFFFFFF), data byte `idx`.
  - `idx`++ each cycle; return to IDLE after the access with `idx`=N-1.
- Load assembly: byte `k` read is stored into accumulator bits [8k+7:8k]. On completion, `resp_data_o` is the accumulator (or aligned `rd_data`), extended per size and `req_signed_i`.
- Store bytes are written one per cycle. `wr_enable` is high for exactly one cycle per byte.
- Idle memif values:
  - `wr_enable`=0
  - `rd_addr`=0, `rd_size`=WORD
  - `wr_addr`=0, `wr_size`=WORD, `wr_data`=0.
- Each cycle drives either the read fields or the write fields; the unused side is held at idle values.

## Timing
- Reset values: `req_ready_o`=1 (FSM=IDLE), `resp_valid_o`=0, `resp_data_o`=0, `idx`=0, accumulator=0, all memif outputs at idle values.
- Latency: `resp_valid_o` asserts exactly N cycles after the accept edge, i.e. on the cycle after the last access is issued.
- Throughput: aligned requests back-to-back, one per cycle. A misaligned request blocks new accepts for N-1 cycles following the accept.
- `resp_valid_o` has no backpressure and is never held more than one cycle.
- `req_*` inputs are ignored while `req_ready_o`=0. They only need to be stable in the accept cycle.
- Reset mid-SPLIT:
  - Returns to IDLE immediately.
  - No `resp_valid_o` is produced for the interrupted request.
  - Bytes already written stay written; no further `wr_enable` is asserted.
- Misaligned WORD crossing 0xFFFFFFFF: byte addresses wrap to 0x0, 0x1, ….

## Structure
- Add to package `definitions`:
  - `mem_align_state_t` (IDLE, SPLIT).
  - Function `mem_size_bytes(mem_access_size_t)` returning 1/2/4.
  - Function `mem_load_extend(data, size, signed)`.
- Single module, no sub-modules. Extension and alignment checks use the package functions.

## Test plan
- Aligned WORD load at 0x100, memory 0xDEADBEEF -> `rd_addr`=0x100, `rd_size`=WORD in the accept cycle; `resp_valid_o` next cycle with 0xDEADBEEF.
- Misaligned WORD store 0x11223344 to 0x201 -> 4 consecutive BYTE writes:
  - 0x201←0x44, 0x202←0x33, 0x203←0x22, 0x204←0x11.
  - `req_ready_o` low for 3 cycles; response 4 cycles after accept.
- Misaligned signed HALF load at 0x301, bytes {0x301:0x80, 0x302:0xFF} -> `resp_data_o`=0xFFFFFF80 after 2 cycles. Same access unsigned -> 0x0000FF80.
- Three back-to-back aligned BYTE loads -> `req_ready_o` stays high; three consecutive `resp_valid_o` pulses with correct data.
- Misaligned WORD load at 0xFFFFFFFE -> byte reads at 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1, in that order.
- Assert `reset_i` on the second byte of a misaligned WORD store -> bytes 0 and 1 written, bytes 2 and 3 not written; no `resp_valid_o`; `req_ready_o`=1 the following cycle.
